// File: rtl/uart_tx_fifo_pkg.sv
// /*----------------------------------------------------------------
//  | uart_tx_fifo_pkg : shared constants and FSM encoding          |
//  | Rev 1.0                                                       |
//  ----------------------------------------------------------------*/
`default_nettype none

package uart_tx_fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STROBE    = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// /*----------------------------------------------------------------
//  | sync_fifo : circular buffer with registered read and flush    |
//  | Rev 1.0                                                       |
//  ----------------------------------------------------------------*/
`default_nettype none

module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     raw_clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] dout_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = dout_q;

    // Flush overrides both a push and a pop in the same cycle.
    assign push_ok = push_i && !full_o  && !flush_i;
    assign pop_ok  = pop_i  && !empty_o && !flush_i;

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // RAM array and its synchronous read port carry no reset.
    always_ff @(posedge raw_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
        if (pop_ok)  dout_q <= mem_q[rd_ptr_q];
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// /*----------------------------------------------------------------
//  | uart_tx_fifo : TX byte queue with transmitter handshake FSM   |
//  | Rev 1.0                                                       |
//  ----------------------------------------------------------------*/
`default_nettype none

module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   raw_clk,
    input  logic                   reset,
    input  logic                   wr_strobe,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   flush,
    input  logic                   clear_overflow,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [WIDTH-1:0]       tx_data,
    output logic                   tx_strobe,
    input  logic                   tx_busy,
    output logic                   idle
);

    tx_state_e        state_q, state_d;
    logic             tx_strobe_q, tx_strobe_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             overflow_q, overflow_d;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_dout;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .raw_clk (raw_clk),
        .reset   (reset),
        .push_i  (wr_strobe),
        .pop_i   (fifo_pop),
        .flush_i (flush),
        .din_i   (wr_data),
        .dout_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tx_strobe_q <= 1'b0;
            tx_data_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_strobe_q <= tx_strobe_d;
            tx_data_q   <= tx_data_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_strobe_d = tx_strobe_q;
        tx_data_d   = tx_data_q;
        fifo_pop    = 1'b0;
        overflow_d  = overflow_q;

        // A dropped push beats a simultaneous clear.
        if (wr_strobe && full)   overflow_d = 1'b1;
        else if (clear_overflow) overflow_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty && !tx_busy && !flush) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_STROBE;
                end
            end
            ST_STROBE: begin
                // First STROBE cycle picks up the registered RAM read.
                if (!tx_strobe_q) begin
                    tx_strobe_d = 1'b1;
                    tx_data_d   = fifo_dout;
                end else if (tx_busy) begin
                    tx_strobe_d = 1'b0;
                    state_d     = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx_strobe = tx_strobe_q;
    assign tx_data   = tx_data_q;
    assign overflow  = overflow_q;
    assign idle      = empty && (state_q == ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// /*----------------------------------------------------------------
//  | tb_uart_tx_fifo : directed self-checking bench for uart_tx_fifo |
//  | Rev 1.0                                                         |
//  ----------------------------------------------------------------*/
`default_nettype none

module tb_uart_tx_fifo;

    logic       raw_clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_strobe = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       clear_overflow = 1'b0;
    logic       tx_busy = 1'b0;
    logic       full, empty, overflow, tx_strobe, idle;
    logic [4:0] count;
    logic [7:0] tx_data;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q [$];
    bit         bm_en = 1'b0;
    bit         bm_rand = 1'b0;
    int         bm_len = 3;
    int         busy_cnt = 0;

    uart_tx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .raw_clk        (raw_clk),
        .reset          (reset),
        .wr_strobe      (wr_strobe),
        .wr_data        (wr_data),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow),
        .tx_data        (tx_data),
        .tx_strobe      (tx_strobe),
        .tx_busy        (tx_busy),
        .idle           (idle)
    );

    always #5 raw_clk = ~raw_clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    // With bm_en set, a transmitter model answers each strobe and scores tx_data.
    task automatic step();
        logic [7:0] e;
        @(posedge raw_clk);
        #1;
        if (bm_en) begin
            if (tx_busy) begin
                if (tx_strobe) begin
                    tests++;
                    fails++;
                    $display("FAIL strobe_while_busy: got tx_strobe=1 expected 0 with tx_busy=1");
                end
                if (busy_cnt == 0) tx_busy = 1'b0;
                else busy_cnt--;
            end else if (tx_strobe) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_strobe: got tx_data=%02h expected no strobe", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        fails++;
                        $display("FAIL tx_byte: got %02h expected %02h", tx_data, e);
                    end
                end
                tx_busy  = 1'b1;
                busy_cnt = bm_rand ? int'($urandom_range(40, 10)) : bm_len;
            end
        end
    endtask

    task automatic do_reset();
        bm_en = 1'b0; bm_rand = 1'b0; tx_busy = 1'b0; busy_cnt = 0;
        wr_strobe = 1'b0; flush = 1'b0; clear_overflow = 1'b0;
        exp_q.delete();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
        tests++; if (empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL reset_flags: got empty=%b full=%b expected 1 0", empty, full); end
        tests++; if (tx_strobe !== 1'b0 || tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx: got strobe=%b data=%02h expected 0 00", tx_strobe, tx_data); end
        tests++; if (overflow !== 1'b0 || idle !== 1'b1) begin fails++; $display("FAIL reset_status: got overflow=%b idle=%b expected 0 1", overflow, idle); end
    endtask

    task automatic test_latency();
        do_reset();
        wr_strobe = 1'b1; wr_data = 8'h41;
        step();
        wr_strobe = 1'b0;
        tests++; if (count !== 5'd1 || tx_strobe !== 1'b0) begin fails++; $display("FAIL lat_push: got count=%0d strobe=%b expected 1 0", count, tx_strobe); end
        step();
        tests++; if (count !== 5'd0 || tx_strobe !== 1'b0) begin fails++; $display("FAIL lat_pop: got count=%0d strobe=%b expected 0 0", count, tx_strobe); end
        step();
        tests++; if (tx_strobe !== 1'b1 || tx_data !== 8'h41) begin fails++; $display("FAIL lat_strobe: got strobe=%b data=%02h expected 1 41", tx_strobe, tx_data); end
        tx_busy = 1'b1;
        step();
        tests++; if (tx_strobe !== 1'b0 || tx_data !== 8'h41) begin fails++; $display("FAIL lat_drop: got strobe=%b data=%02h expected 0 41", tx_strobe, tx_data); end
        step();
        tx_busy = 1'b0;
        step();
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL lat_idle: got idle=%b expected 1", idle); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_strobe = 1'b1; wr_data = 8'(i);
            exp_q.push_back(8'(i));
            step();
        end
        wr_strobe = 1'b0;
        tests++; if (full !== 1'b1 || count !== 5'd16) begin fails++; $display("FAIL fill_full: got full=%b count=%0d expected 1 16", full, count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL fill_no_ovf: got overflow=%b expected 0", overflow); end
        wr_strobe = 1'b1; wr_data = 8'h10;
        step();
        wr_strobe = 1'b0;
        tests++; if (overflow !== 1'b1 || count !== 5'd16) begin fails++; $display("FAIL drop_ovf: got overflow=%b count=%0d expected 1 16", overflow, count); end
        wr_strobe = 1'b1; wr_data = 8'h11; clear_overflow = 1'b1;
        step();
        wr_strobe = 1'b0;
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_priority: got overflow=%b expected 1", overflow); end
        step();
        clear_overflow = 1'b0;
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got overflow=%b expected 0", overflow); end
        bm_en = 1'b1; bm_len = 3; busy_cnt = 0; tx_busy = 1'b0;
        for (int i = 0; i < 600 && exp_q.size() > 0; i++) step();
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL drain_timeout: got %0d bytes left expected 0", exp_q.size()); end
        for (int i = 0; i < 20; i++) step();
        bm_en = 1'b0; tx_busy = 1'b0;
        step();
        tests++; if (count !== 5'd0 || idle !== 1'b1) begin fails++; $display("FAIL drain_end: got count=%0d idle=%b expected 0 1", count, idle); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_strobe = 1'b1; wr_data = 8'(i);
            step();
        end
        tx_busy = 1'b0; wr_strobe = 1'b1; wr_data = 8'h20;
        step();
        wr_strobe = 1'b0;
        tests++; if (count !== 5'd15 || overflow !== 1'b1) begin fails++; $display("FAIL full_pop_push: got count=%0d overflow=%b expected 15 1", count, overflow); end
        step();
        tests++; if (tx_strobe !== 1'b1 || tx_data !== 8'h00) begin fails++; $display("FAIL sc_first: got strobe=%b data=%02h expected 1 00", tx_strobe, tx_data); end
        tx_busy = 1'b1;
        step();
        tx_busy = 1'b0;
        step();
        wr_strobe = 1'b1; wr_data = 8'h21;
        step();
        wr_strobe = 1'b0;
        tests++; if (count !== 5'd15) begin fails++; $display("FAIL push_pop_15: got count=%0d expected 15", count); end
        step();
        tests++; if (tx_strobe !== 1'b1 || tx_data !== 8'h01) begin fails++; $display("FAIL sc_second: got strobe=%b data=%02h expected 1 01", tx_strobe, tx_data); end
    endtask

    task automatic test_flush();
        bit seen;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_strobe = 1'b1; wr_data = 8'(8'h51 + i);
            step();
        end
        wr_strobe = 1'b0;
        tests++; if (count !== 5'd4 || tx_strobe !== 1'b1 || tx_data !== 8'h51) begin fails++; $display("FAIL pre_flush: got count=%0d strobe=%b data=%02h expected 4 1 51", count, tx_strobe, tx_data); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests++; if (count !== 5'd0 || tx_strobe !== 1'b1 || tx_data !== 8'h51) begin fails++; $display("FAIL flush_keep: got count=%0d strobe=%b data=%02h expected 0 1 51", count, tx_strobe, tx_data); end
        tx_busy = 1'b1;
        step();
        tests++; if (tx_strobe !== 1'b0) begin fails++; $display("FAIL flush_done: got strobe=%b expected 0", tx_strobe); end
        step();
        tx_busy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (tx_strobe) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0 || idle !== 1'b1) begin fails++; $display("FAIL flush_quiet: got strobe_seen=%b idle=%b expected 0 1", seen, idle); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr_strobe = 1'b1; wr_data = 8'hA1;
        step();
        wr_strobe = 1'b0;
        step();
        step();
        tx_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_strobe = 1'b1; wr_data = 8'(8'hB0 + i);
            step();
        end
        wr_strobe = 1'b0;
        tests++; if (count !== 5'd3 || tx_strobe !== 1'b0 || idle !== 1'b0) begin fails++; $display("FAIL mid_pre: got count=%0d strobe=%b idle=%b expected 3 0 0", count, tx_strobe, idle); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        tests++; if (tx_strobe !== 1'b0 || count !== 5'd0) begin fails++; $display("FAIL mid_rst: got strobe=%b count=%0d expected 0 0", tx_strobe, count); end
        tests++; if (empty !== 1'b1 || idle !== 1'b1) begin fails++; $display("FAIL mid_rst_idle: got empty=%b idle=%b expected 1 1", empty, idle); end
        tx_busy = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        bm_en = 1'b1; bm_rand = 1'b1;
        for (int burst = 0; burst < 2; burst++) begin
            for (int i = 0; i < (burst == 0 ? 12 : 8); i++) begin
                wr_strobe = 1'b1; wr_data = 8'(8'hA0 + burst * 12 + i);
                exp_q.push_back(wr_data);
                step();
            end
            wr_strobe = 1'b0;
            for (int i = 0; i < 1500 && exp_q.size() > 0; i++) step();
            tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL wrap_timeout: got %0d bytes left expected 0", exp_q.size()); end
            for (int i = 0; i < 60 && tx_busy; i++) step();
            step();
            step();
        end
        bm_en = 1'b0;
        tests++; if (count !== 5'd0 || idle !== 1'b1 || overflow !== 1'b0) begin fails++; $display("FAIL wrap_end: got count=%0d idle=%b overflow=%b expected 0 1 0", count, idle, overflow); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_overflow();
        test_same_cycle();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16; FIFO entries; power of two, 2 to 256.
REQ-002 Parameter WIDTH, default 8; data width in bits.
REQ-003 raw_clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_strobe  input  1  one-cycle push request from the peripheral register write path.
REQ-006 wr_data  input  WIDTH  byte to enqueue; sampled when wr_strobe=1.
REQ-007 flush  input  1  discard all queued, unsent entries.
REQ-008 clear_overflow  input  1  clears the overflow flag.
REQ-009 full  output  1  count == DEPTH.
REQ-010 empty  output  1  count == 0.
REQ-011 count  output  $clog2(DEPTH)+1  entries currently queued, excluding the byte held in tx_data.
REQ-012 overflow  output  1  sticky; a push was dropped.
REQ-013 tx_data  output  WIDTH  byte presented to the UART transmitter.
REQ-014 tx_strobe  output  1  send request to the UART transmitter.
REQ-015 tx_busy  input  1  UART transmitter is busy.
REQ-016 idle  output  1  high when the FIFO is empty and the FSM is in IDLE.

Function
REQ-017 Storage is a circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits; both wrap from DEPTH-1 to 0.
REQ-018 Push: if wr_strobe=1 and full=0, write wr_data at wr_ptr, increment wr_ptr and count.
REQ-019 Push when full=0 is accepted even if a pop occurs in the same cycle.
REQ-020 Push when full=1 is dropped and sets overflow, regardless of a same-cycle pop.
REQ-021 Simultaneous push and pop leave count unchanged; both pointers advance.
REQ-022 FSM states are IDLE, STROBE and WAIT_DONE.
REQ-023 IDLE: if empty=0 and tx_busy=0, pop the head into tx_data, assert tx_strobe on the next cycle, and go to STROBE.
REQ-024 STROBE: hold tx_strobe=1 and tx_data stable until tx_busy=1 is sampled; then drop tx_strobe and go to WAIT_DONE.
REQ-025 WAIT_DONE: remain until tx_busy=0, then go to IDLE.
REQ-026 Latency: a push into an empty FIFO in IDLE (tx_busy=0) at edge N gives tx_strobe=1 after edge N+2, with the pop at edge N+1.
REQ-027 Throughput: at most one byte per transmitter busy period; no byte is issued while tx_busy=1.
REQ-028 flush=1 sets rd_ptr equal to wr_ptr and count to 0; a push in the same cycle is dropped.
REQ-029 flush does not abort the FSM; a byte already in STROBE or WAIT_DONE completes normally.
REQ-030 overflow clears on clear_overflow=1; a drop in the same cycle takes priority and overflow stays 1.
REQ-031 tx_data holds its last value when tx_strobe=0.

Reset
REQ-032 On reset: wr_ptr=0, rd_ptr=0, count=0, FSM=IDLE, tx_strobe=0, tx_data=0, overflow=0.
REQ-033 Storage contents are not reset.
REQ-034 Reset asserted mid-transfer drops tx_strobe the next cycle and discards all queued data.
REQ-035 After reset the block is ready for a push on the first cycle reset=0.

Structure
REQ-036 FSM state encoding and the default DEPTH constant live in the shared peripherals package.
REQ-037 The circular buffer is one sub-module, sync_fifo, with push, pop, flush, full, empty and count.
REQ-038 The handshake FSM and overflow logic reside in uart_tx_fifo itself.
REQ-039 Storage infers block RAM or distributed RAM with no asynchronous read of reset-dependent state.

Verification
REQ-040 Push 0x41 into an empty FIFO with tx_busy=0 -> tx_strobe=1 two cycles later with tx_data=0x41; busy response model asserts tx_busy -> tx_strobe drops the next cycle.
REQ-041 Push 0x00..0x0F back-to-back while tx_busy=1 -> full=1 and count=16; push 0x10 -> dropped and overflow=1; release busy -> bytes 0x00..0x0F emitted in order with no duplicates.
REQ-042 Fill to 16 and push while the FSM pops in the same cycle -> push dropped and overflow=1 (REQ-020); at count=15, same-cycle push and pop -> count stays 15.
REQ-043 Queue 5 bytes with the first in STROBE, then assert flush -> first byte completes, count=0, no further tx_strobe.
REQ-044 Assert reset while in WAIT_DONE with 3 bytes queued -> tx_strobe=0, count=0, empty=1, idle=1 the cycle after reset deasserts.
REQ-045 Push 20 bytes with DEPTH=16 and a randomised tx_busy duration of 10-40 cycles -> pointer wrap is exercised and the scoreboard matches all accepted bytes.
